// File: rtl/piece_fit_checker.sv
// Sequential legality checker for a candidate Tetris placement: scans the 4x4 piece grid one column per cycle.
// Build option: define PIECE_ABOVE_TOP_EN to allow filled cells above the visible field (by<0).

package game_state_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef struct packed {
        logic [BOARD_W-1:0][BOARD_H-1:0] screen;
    } game_state_t;
endpackage

package tetris_pkg;
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic [3:0][3:0]    piece;
    } active_piece_grid_t;
endpackage

module piece_fit_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  game_state_pkg::game_state_t     board,
    input  tetris_pkg::active_piece_grid_t  candidate,
    output logic                            busy,
    output logic                            done,
    output logic                            fits,
    output logic                            hit_board,
    output logic                            hit_wall,
    output logic                            hit_floor,
    output logic                            hit_top
);

    localparam int XW = $clog2(BOARD_W);
    localparam int YW = $clog2(BOARD_H);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e                          state_q;
    logic [1:0]                      col_q;
    game_state_pkg::game_state_t     board_q;
    tetris_pkg::active_piece_grid_t  cand_q;

    logic busy_q, done_q, fits_q;
    logic hit_board_q, hit_wall_q, hit_floor_q, hit_top_q;

    // Per-column fault contributions and the sticky flags they would produce.
    logic col_board, col_wall, col_floor, col_top;
    logic hit_board_d, hit_wall_d, hit_floor_d, hit_top_d;
    logic signed [31:0] bx, by;
    logic [XW-1:0] bx_idx;
    logic [YW-1:0] by_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_board = 1'b0;
        col_wall  = 1'b0;
        col_floor = 1'b0;
        col_top   = 1'b0;
        bx        = cand_q.x + $signed({30'd0, col_q});
        by        = '0;
        bx_idx    = bx[XW-1:0];
        by_idx    = '0;
        for (int dy = 0; dy < 4; dy++) begin
            by     = cand_q.y + dy;
            by_idx = by[YW-1:0];
            if (cand_q.piece[col_q][dy]) begin
                if (bx < 0 || bx >= BOARD_W) begin
                    col_wall = 1'b1;
                end else if (by >= BOARD_H) begin
                    col_floor = 1'b1;
                end else if (by < 0) begin
`ifndef PIECE_ABOVE_TOP_EN
                    col_top = 1'b1;
`endif
                end else if (board_q.screen[bx_idx][by_idx]) begin
                    col_board = 1'b1;
                end
            end
        end
    end

    assign hit_board_d = hit_board_q | col_board;
    assign hit_wall_d  = hit_wall_q  | col_wall;
    assign hit_floor_d = hit_floor_q | col_floor;
    assign hit_top_d   = hit_top_q   | col_top;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            // NOTE: the snapshot registers are reset too, so the idle datapath never sees X.
            board_q     <= '0;
            cand_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fits_q      <= 1'b0;
            hit_board_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_floor_q <= 1'b0;
            hit_top_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        board_q     <= board;
                        cand_q      <= candidate;
                        col_q       <= 2'd0;
                        busy_q      <= 1'b1;
                        fits_q      <= 1'b0;
                        hit_board_q <= 1'b0;
                        hit_wall_q  <= 1'b0;
                        hit_floor_q <= 1'b0;
                        hit_top_q   <= 1'b0;
                        state_q     <= SCAN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    hit_board_q <= hit_board_d;
                    hit_wall_q  <= hit_wall_d;
                    hit_floor_q <= hit_floor_d;
                    hit_top_q   <= hit_top_d;
                    if (col_q == 2'd3) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fits_q  <= !(hit_board_d | hit_wall_d | hit_floor_d | hit_top_d);
                        state_q <= DONE;
                    end else begin
                        col_q <= col_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fits      = fits_q;
    assign hit_board = hit_board_q;
    assign hit_wall  = hit_wall_q;
    assign hit_floor = hit_floor_q;
    assign hit_top   = hit_top_q;

endmodule
